// File: rtl/fetch_controller.sv
// Instruction fetch controller: IDLE/RUN/HALT sequencing, a single registered
// output slot with valid/ready handshake, redirect with flush, handshake counter.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt_req,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        running,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned WIDXW = XLEN - 2;
  localparam logic [WIDXW-1:0] RESET_WIDX = RESET_PC[XLEN-1:2];

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  // PC is kept as a word index; the byte offset is always zero.
  logic [WIDXW-1:0]  r_pc;
  logic [WIDXW-1:0]  w_pc_nxt;
  logic [XLEN-1:0]   r_instr;
  logic [XLEN-1:0]   w_instr_nxt;
  logic [WIDXW-1:0]  r_instr_pc;
  logic [WIDXW-1:0]  w_instr_pc_nxt;
  logic              r_instr_valid;
  logic              w_instr_valid_nxt;
  logic              r_running;
  logic              w_running_nxt;
  logic [XLEN-1:0]   r_fetch_count;
  logic [XLEN-1:0]   w_fetch_count_nxt;

  logic              w_hs;
  logic              w_slot_free;
  logic              w_unused;

  assign w_hs        = r_instr_valid & instr_ready;
  assign w_slot_free = ~r_instr_valid | w_hs;
  assign w_unused    = &{1'b0, redirect_pc[1:0]};

  // State, datapath and counter next values.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_instr_nxt       = r_instr;
    w_instr_pc_nxt    = r_instr_pc;
    w_instr_valid_nxt = r_instr_valid;
    w_fetch_count_nxt = r_fetch_count;

    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (halt_req && (!r_instr_valid || w_hs || redirect)) w_state_nxt = ST_HALT;
      ST_HALT: if (start && !halt_req) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_IDLE;
    endcase

    // Redirect flushes the slot and suppresses any fetch in the same cycle.
    if (redirect) begin
      w_pc_nxt          = redirect_pc[XLEN-1:2];
      w_instr_valid_nxt = 1'b0;
    end else if (r_state == ST_RUN) begin
      if (!halt_req) begin
        if (w_slot_free) begin
          w_instr_nxt       = imem_data;
          w_instr_pc_nxt    = r_pc;
          w_instr_valid_nxt = 1'b1;
          w_pc_nxt          = r_pc + WIDXW'(1);
        end
      end else if (w_hs) begin
        w_instr_valid_nxt = 1'b0;
      end
    end else begin
      w_instr_valid_nxt = 1'b0;
    end

    if (w_hs && !redirect) begin
      w_fetch_count_nxt = r_fetch_count + XLEN'(1);
    end

    w_running_nxt = (w_state_nxt == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_WIDX;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_running     <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_pc    <= w_instr_pc_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_running     <= w_running_nxt;
      r_fetch_count <= w_fetch_count_nxt;
    end
  end

  assign imem_addr   = {2'b00, r_pc};
  assign instr       = r_instr;
  assign instr_pc    = {r_instr_pc, 2'b00};
  assign instr_valid = r_instr_valid;
  assign running     = r_running;
  assign fetch_count = r_fetch_count;

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the byte address loaded into the PC on reset; bits [1:0] SHALL be treated as 0.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  level; moves IDLE/HALT to RUN.
REQ-005 halt_req  input  1  level; stops fetching from RUN.
REQ-006 redirect  input  1  one-cycle pulse; load new PC and flush the output.
REQ-007 redirect_pc  input  32  byte target address, sampled when redirect=1.
REQ-008 imem_addr  output  32  word index to instruction memory = {2'b00, pc[31:2]}, combinational from pc.
REQ-009 imem_data  input  32  instruction word, combinationally valid in the same cycle as imem_addr.
REQ-010 instr  output  32  registered instruction for decode.
REQ-011 instr_pc  output  32  byte address of instr.
REQ-012 instr_valid  output  1  instr/instr_pc hold a valid instruction.
REQ-013 instr_ready  input  1  consumer accepts; handshake = instr_valid & instr_ready.
REQ-014 running  output  1  1 iff state = RUN.
REQ-015 fetch_count  output  32  number of completed handshakes since reset.

Function
REQ-016 State machine SHALL have exactly three states: IDLE, RUN, HALT.
REQ-017 IDLE -> RUN when start=1; HALT -> RUN when start=1 and halt_req=0; otherwise hold.
REQ-018 RUN -> HALT when halt_req=1 and (instr_valid=0 or handshake this cycle or redirect=1).
REQ-019 In RUN with halt_req=0, "slot free" = instr_valid=0 or handshake; when slot free: instr<=imem_data, instr_pc<=pc, instr_valid<=1, pc<=pc+4.
REQ-020 In RUN, instr_valid=1 and instr_ready=0: instr, instr_pc, instr_valid, pc SHALL all hold (no drop, no duplicate).
REQ-021 Fetch latency: instruction at pc appears on instr exactly one cycle after slot free in RUN.
REQ-022 redirect=1 (any state) has highest priority: pc<={redirect_pc[31:2],2'b00}, instr_valid<=0, no fetch that cycle; the output instruction is discarded even if instr_ready=1 and is not counted.
REQ-023 After redirect in RUN, the next cycle fetches from the new pc (one bubble cycle).
REQ-024 redirect with halt_req=1 in RUN: pc updated, instr_valid<=0, state<=HALT.
REQ-025 halt_req in RUN with pending un-accepted instruction: no new fetch; hold output until handshake, then instr_valid<=0 and state<=HALT.
REQ-026 In IDLE/HALT: no fetch; instr_valid SHALL be 0; redirect still updates pc.
REQ-027 pc increments modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-028 fetch_count increments by 1 per handshake (excluding REQ-022), wraps modulo 2^32.
REQ-029 start and halt_req both 1 in RUN: halt_req wins.

Reset
REQ-030 rst_n=0 SHALL immediately force: state=IDLE, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, fetch_count=0, running=0.
REQ-031 Reset asserted mid-RUN SHALL discard any pending instruction; after release the block stays in IDLE until start.

Verification
REQ-032 Reset release, start=1, instr_ready=1, memory words 0..3 = 32'hE580_100A, A, B, C -> instr sequence E580_100A/A/B/C with instr_pc 0,4,8,C on consecutive cycles starting 1 cycle after start; fetch_count=4.
REQ-033 instr_ready=0 for 3 cycles while instr_pc=4 -> instr/instr_pc/imem_addr stable, pc=8 held; on ready=1 next instr_pc=8, no gap or repeat.
REQ-034 redirect=1, redirect_pc=32'h0000_0043 while instr_valid=1, instr_ready=1 -> instr_valid=0 next cycle, fetch_count unchanged, following instr_pc=32'h0000_0040, imem_addr=32'h10.
REQ-035 halt_req=1 with instr_valid=1, instr_ready=0 for 2 cycles then ready=1 -> output held, one handshake, then running=0, instr_valid=0; start=1 with halt_req=0 resumes at next pc.
REQ-036 redirect_pc=32'hFFFF_FFFC, run with ready=1 -> instr_pc FFFF_FFFC then 0000_0000.
REQ-037 rst_n=0 asynchronously mid-RUN between clock edges -> all outputs at reset values before next edge; no fetch until start.
